// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO pair.
// It also services MFHI/MFLO/MTHI/MTLO and stalls HI/LO users while an operation is in flight.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// combinational multiplier and go straight from IDLE to ADJ.
`timescale 1ns/1ps
module muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [5:0]      op_i,
  input  logic [5:0]      funct_i,
  input  logic [XLEN-1:0] rs_data_i,
  input  logic [XLEN-1:0] rt_data_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic            div_zero_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, ADJ = 2'd2} state_t;

  state_t            state_reg;
  logic [CW-1:0]     count_reg;
  // Multiply: {partial product upper, multiplier shifting out}.
  // Divide: {remainder, dividend shifting into quotient}.
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   opnd_reg;    // multiplicand or divisor magnitude
  logic [XLEN-1:0]   rs_raw_reg;  // raw dividend, returned in HI on divide-by-zero
  logic              is_div_reg;
  logic              neg_lo_reg;  // negate product / quotient
  logic              neg_hi_reg;  // negate remainder (sign of dividend)
  logic              dz_reg;

  // Instruction decode
  logic            is_special, start, hilo_acc, is_signed, is_div_op;
  logic            rs_neg, rt_neg;
  logic [XLEN-1:0] rs_mag, rt_mag;

  assign is_special = valid_i && (op_i == 6'h00);
  assign start      = is_special && (funct_i[5:2] == 4'b0110);  // 0x18..0x1B
  assign hilo_acc   = is_special && (funct_i[5:2] == 4'b0100);  // 0x10..0x13
  assign is_signed  = ~funct_i[0];
  assign is_div_op  = funct_i[1];
  assign rs_neg     = is_signed & rs_data_i[XLEN-1];
  assign rt_neg     = is_signed & rt_data_i[XLEN-1];
  assign rs_mag     = rs_neg ? -rs_data_i : rs_data_i;
  assign rt_mag     = rt_neg ? -rt_data_i : rt_data_i;

  assign busy_o  = (state_reg != IDLE);
  assign stall_o = busy_o & (start | hilo_acc);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, rs_mag} * {{XLEN{1'b0}}, rt_mag};
`endif

  // One shift-add (multiply) or restoring shift-subtract (divide) step
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
    mul_next  = {mul_sum, acc_reg[XLEN-1:1]};
    div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd_reg});
    // When div_ge holds the true difference is below the divisor, so XLEN bits suffice.
    div_diff  = div_shift[XLEN-1:0] - opnd_reg;
    div_next  = div_ge ? {div_diff, acc_reg[XLEN-2:0], 1'b1}
                       : {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
  end

  // Final sign fix-up and HI/LO selection written in ADJ
  logic [2*XLEN-1:0] mul_res;
  logic [XLEN-1:0]   adj_hi, adj_lo;

  always_comb begin
    mul_res = neg_lo_reg ? -acc_reg : acc_reg;
    adj_hi  = mul_res[2*XLEN-1:XLEN];
    adj_lo  = mul_res[XLEN-1:0];
    if (dz_reg) begin
      adj_hi = rs_raw_reg;
      adj_lo = {XLEN{1'b1}};
    end else if (is_div_reg) begin
      adj_hi = neg_hi_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
      adj_lo = neg_lo_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    end
  end

  // Sequencer FSM with HI/LO and pulse outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      rs_raw_reg <= '0;
      is_div_reg <= 1'b0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      dz_reg     <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            opnd_reg   <= is_div_op ? rt_mag : rs_mag;
            acc_reg    <= {{XLEN{1'b0}}, (is_div_op ? rs_mag : rt_mag)};
            rs_raw_reg <= rs_data_i;
            is_div_reg <= is_div_op;
            neg_lo_reg <= rs_neg ^ rt_neg;
            neg_hi_reg <= rs_neg;
            dz_reg     <= is_div_op && (rt_data_i == '0);
            count_reg  <= '0;
            if (is_div_op && (rt_data_i == '0)) begin
              state_reg <= ADJ;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div_op) begin
              acc_reg   <= fast_prod;
              state_reg <= ADJ;
            end
`endif
            else begin
              state_reg <= CALC;
            end
          end else if (is_special && (funct_i == 6'h11)) begin
            hi_o <= rs_data_i;
          end else if (is_special && (funct_i == 6'h13)) begin
            lo_o <= rs_data_i;
          end
        end
        CALC: begin
          acc_reg   <= is_div_reg ? div_next : mul_next;
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(XLEN-1)) begin
            state_reg <= ADJ;
          end
        end
        ADJ: begin
          hi_o       <= adj_hi;
          lo_o       <= adj_lo;
          done_o     <= 1'b1;
          div_zero_o <= dz_reg;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors for muldiv_ctrl with a queue-based scoreboard.
// Stimulus pushes expected HI/LO/div_zero; a monitor pops on each done_o pulse.
`timescale 1ns/1ps
module tb_muldiv_ctrl;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = XLEN + 2;
`endif
  localparam int DIV_LAT = XLEN + 2;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid_i;
  logic [5:0]      op_i, funct_i;
  logic [XLEN-1:0] rs_data_i, rt_data_i;
  logic [XLEN-1:0] hi_o, lo_o;
  logic            busy_o, stall_o, done_o, div_zero_o;

  muldiv_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .op_i(op_i), .funct_i(funct_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .hi_o(hi_o), .lo_o(lo_o),
    .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o), .div_zero_o(div_zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            dz;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Monitor: every done_o pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!reset && done_o) begin
      $display("done: hi=%h lo=%h div_zero=%b", hi_o, lo_o, div_zero_o);
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL sb_empty: got done_o=1 want no result pending");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", 64'(hi_o), 64'(e.hi));
        check("lo", 64'(lo_o), 64'(e.lo));
        check("div_zero", 64'(div_zero_o), 64'(e.dz));
      end
    end
  end

  task automatic drive(input logic v, input logic [5:0] funct,
                       input logic [XLEN-1:0] rs, input logic [XLEN-1:0] rt);
    valid_i   = v;
    op_i      = 6'h00;
    funct_i   = funct;
    rs_data_i = rs;
    rt_data_i = rt;
  endtask

  // Issue one op in cycle 0, then check done cycle and busy profile
  task automatic do_op(input string name, input logic [5:0] funct,
                       input logic [XLEN-1:0] rs, input logic [XLEN-1:0] rt,
                       input logic [XLEN-1:0] ehi, input logic [XLEN-1:0] elo,
                       input logic edz, input int lat);
    exp_t e;
    int   done_cyc;
    int   bad_busy;
    e.hi = ehi; e.lo = elo; e.dz = edz;
    sb.push_back(e);
    @(posedge clk); #1;
    drive(1'b1, funct, rs, rt);
    @(posedge clk); #1;
    drive(1'b0, 6'h00, '0, '0);
    done_cyc = -1;
    bad_busy = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done_o) begin
        done_cyc = c;
        if (busy_o) bad_busy++;
        break;
      end else if (!busy_o) begin
        bad_busy++;
      end
    end
    $display("op %s rs=%h rt=%h done_cycle=%0d", name, rs, rt, done_cyc);
    check({name, "_latency"}, 64'(done_cyc), 64'(lat));
    check({name, "_busy"}, 64'(bad_busy), 64'd0);
  endtask

  initial begin
    int bad_add, bad_mflo, dones;
    exp_t e;
    reset = 1'b1;
    drive(1'b0, 6'h00, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_div_zero", 64'(div_zero_o), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, MUL_LAT);
    do_op("mult_neg",  F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, MUL_LAT);
    do_op("mult_min",  F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, MUL_LAT);
    do_op("div_neg",   F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT);
    do_op("div_negrt", F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, DIV_LAT);
    do_op("divu",      F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, DIV_LAT);
    do_op("div_ovf",   F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, DIV_LAT);
    do_op("divu_zero", F_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 2);
    do_op("div_zero",  F_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 2);

    // MULT 5*6 with ADD in cycles 1..4 and MFLO held from cycle 5
    e.hi = 32'd0; e.lo = 32'd30; e.dz = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    drive(1'b1, F_MULT, 32'd5, 32'd6);
    bad_add = 0;
    bad_mflo = 0;
    for (int c = 1; c <= 34; c++) begin
      @(posedge clk); #1;
      if (c < 5) drive(1'b1, F_ADD, 32'd1, 32'd2);
      else       drive(1'b1, F_MFLO, '0, '0);
      @(negedge clk);
      if (c < 5 && stall_o) bad_add++;
      if (c >= 5 && c <= 33 && !stall_o) bad_mflo++;
      if (c == 34) begin
        check("stall_release", 64'(stall_o), 64'd0);
        check("mflo_done", 64'(done_o), 64'd1);
        check("mflo_value", 64'(lo_o), 64'd30);
      end
    end
    $display("op stall_test add_stalls=%0d mflo_gaps=%0d", bad_add, bad_mflo);
    check("stall_add", 64'(bad_add), 64'd0);
    check("stall_mflo", 64'(bad_mflo), 64'd0);
    @(posedge clk); #1;
    drive(1'b0, 6'h00, '0, '0);

    // MTHI / MTLO while idle
    @(posedge clk); #1;
    drive(1'b1, F_MTHI, 32'hA5A5A5A5, '0);
    @(posedge clk); #1;
    drive(1'b0, 6'h00, '0, '0);
    @(negedge clk);
    $display("op mthi hi=%h", hi_o);
    check("mthi", 64'(hi_o), 64'hA5A5A5A5);
    @(posedge clk); #1;
    drive(1'b1, F_MTLO, 32'h5A5A5A5A, '0);
    @(posedge clk); #1;
    drive(1'b1, F_MFHI, '0, '0);
    @(negedge clk);
    $display("op mtlo lo=%h", lo_o);
    check("mtlo", 64'(lo_o), 64'h5A5A5A5A);
    check("mfhi_idle_stall", 64'(stall_o), 64'd0);

    // Reset in cycle 10 of a DIV: aborts, clears HI/LO, no done_o
    @(posedge clk); #1;
    drive(1'b1, F_DIV, 32'd100, 32'd7);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      drive(1'b0, 6'h00, '0, '0);
      if (c == 10) reset = 1'b1;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    $display("op reset_abort busy=%b hi=%h lo=%h", busy_o, hi_o, lo_o);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_hi", 64'(hi_o), 64'd0);
    check("abort_lo", 64'(lo_o), 64'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
